// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IW          = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          ptr,
    output logic [NUM_MASTERS-1:0] onehot,
    output logic [IW-1:0]          idx,
    output logic                   found
);

    always_comb begin
        int c;
        c      = 0;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            c = (int'(ptr) + k) % NUM_MASTERS;
            if (!found && req[c]) begin
                found     = 1'b1;
                onehot[c] = 1'b1;
                idx       = c[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native valid/ready memory bus between masters,
// with a release cycle between transactions and a watchdog for dead slaves.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_EN     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_MASTERS-1:0]    m_valid,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
    output logic [NUM_MASTERS-1:0]    m_ready,
    output logic [31:0]               m_rdata,
    output logic                      s_valid,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_wstrb,
    input  logic                      s_ready,
    input  logic [31:0]               s_rdata,
    output logic [NUM_MASTERS-1:0]    grant,
    output logic                      busy,
    output logic                      timeout_pulse
);

    localparam int IW = (clog2(NUM_MASTERS) < 1) ? 1 : clog2(NUM_MASTERS);
    localparam int WW = clog2(TIMEOUT_CYCLES + 1);

    arb_state_e             state;
    logic [IW-1:0]          gidx;
    logic [IW-1:0]          rr_ptr;
    logic [WW-1:0]          wd_cnt;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [IW-1:0]          win_idx;
    logic                   win_found;
    logic                   in_grant, g_valid, wd_hit, done, to_now;

    rr_priority_picker #(.NUM_MASTERS(NUM_MASTERS), .IW(IW)) u_picker (
        .req    (m_valid),
        .ptr    (rr_ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .found  (win_found)
    );

    assign in_grant = (state == GRANT);
    assign g_valid  = |(m_valid & grant);
    assign wd_hit   = (TIMEOUT_EN != 0) && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    // An s_ready with no outstanding request is not a completion.
    assign done     = in_grant & g_valid & s_ready;
    assign to_now   = in_grant & g_valid & ~s_ready & wd_hit;

    assign s_valid  = in_grant & g_valid;
    assign m_ready  = (done | to_now) ? grant : '0;
    assign m_rdata  = to_now ? TIMEOUT_RDATA : s_rdata;
    assign busy     = (state != IDLE);

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (|grant) begin
            s_addr  = m_addr[int'(gidx)*32 +: 32];
            s_wdata = m_wdata[int'(gidx)*32 +: 32];
            s_wstrb = m_wstrb[int'(gidx)*4 +: 4];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            grant         <= '0;
            gidx          <= '0;
            rr_ptr        <= '0;
            wd_cnt        <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= to_now;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant  <= win_oh;
                        gidx   <= win_idx;
                        wd_cnt <= '0;
                        rr_ptr <= (win_idx == IW'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    // Completion, watchdog expiry and master abort all release the bus.
                    if (done || to_now || !g_valid) begin
                        grant <= '0;
                        state <= RELEASE;
                    end else if (TIMEOUT_EN != 0) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with two masters and a short watchdog.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  m_valid;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_ready;
    logic [31:0] m_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        busy, timeout_pulse;
    logic        auto_ready, s_ready_man;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Simple slave: either acknowledges instantly or follows the manual ready.
    assign s_ready = auto_ready ? s_valid : s_ready_man;

    mem_bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT_EN(1), .TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .m_valid       (m_valid),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_wstrb       (m_wstrb),
        .m_ready       (m_ready),
        .m_rdata       (m_rdata),
        .s_valid       (s_valid),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_wstrb       (s_wstrb),
        .s_ready       (s_ready),
        .s_rdata       (s_rdata),
        .grant         (grant),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_rdata = '0; auto_ready = 1'b0; s_ready_man = 1'b0;
        m_addr[31:0]  = 32'h0000_0010;
        m_addr[63:32] = 32'h2000_0004;
        step(); #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_svalid", 32'(s_valid), 0);
        chk("rst_mready", 32'(m_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tp", 32'(timeout_pulse), 0);
        step(); resetn = 1'b1;

        // single read by master 0, slave answers on the third GRANT cycle
        step(); m_valid = 2'b01; #1;
        chk("t1_idle_svalid", 32'(s_valid), 0);
        step(); #1;
        chk("t1_svalid", 32'(s_valid), 1);
        chk("t1_grant", 32'(grant), 1);
        chk("t1_saddr", s_addr, 32'h0000_0010);
        chk("t1_mready_wait", 32'(m_ready), 0);
        step(); #1;
        chk("t1_mready_wait2", 32'(m_ready), 0);
        step(); s_ready_man = 1'b1; s_rdata = 32'h1234_5678; #1;
        chk("t1_mready", 32'(m_ready), 1);
        chk("t1_rdata", m_rdata, 32'h1234_5678);
        step(); s_ready_man = 1'b0; m_valid = '0; #1;
        chk("t1_rel_grant", 32'(grant), 0);
        chk("t1_rel_mready", 32'(m_ready), 0);
        chk("t1_rel_busy", 32'(busy), 1);
        step(); #1;
        chk("t1_idle_busy", 32'(busy), 0);

        // reset so the pointer starts at 0, then both masters request continuously
        resetn = 1'b0; step(); resetn = 1'b1;
        auto_ready = 1'b1; m_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step(); #1;
            chk($sformatf("rr%0d_grant", i), 32'(grant), (i % 2 == 0) ? 1 : 2);
            chk($sformatf("rr%0d_mready", i), 32'(m_ready), (i % 2 == 0) ? 1 : 2);
            chk($sformatf("rr%0d_saddr", i), s_addr, (i % 2 == 0) ? 32'h0000_0010 : 32'h2000_0004);
            step(); #1;
            chk($sformatf("rr%0d_rel", i), {30'd0, grant | m_ready}, 0);
            step();
            if (i == 7) m_valid = '0;
            #1;
            chk($sformatf("rr%0d_idle", i), {30'd0, grant | m_ready}, 0);
        end
        auto_ready = 1'b0;

        // watchdog: master 0, slave never answers
        m_valid = 2'b01; s_rdata = 32'h5555_0000;
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            chk($sformatf("to_mready%0d", k), 32'(m_ready), (k == 3) ? 1 : 0);
            chk($sformatf("to_tp%0d", k), 32'(timeout_pulse), 0);
        end
        chk("to_rdata", m_rdata, 32'hFFFF_FFFF);
        step(); m_valid = '0; #1;
        chk("to_pulse", 32'(timeout_pulse), 1);
        chk("to_rel_grant", 32'(grant), 0);
        step(); #1;
        chk("to_pulse_off", 32'(timeout_pulse), 0);
        m_valid = 2'b10;
        step(); s_ready_man = 1'b1; s_rdata = 32'h0BAD_F00D; #1;
        chk("after_to_mready", 32'(m_ready), 2);
        chk("after_to_rdata", m_rdata, 32'h0BAD_F00D);
        step(); s_ready_man = 1'b0; m_valid = '0; #1;
        chk("after_to_tp", 32'(timeout_pulse), 0);
        step();

        // s_ready lands exactly on the would-be timeout cycle
        m_valid = 2'b01;
        for (int k = 0; k < 3; k++) step();
        step(); s_ready_man = 1'b1; s_rdata = 32'hA5A5_A5A5; #1;
        chk("edge_mready", 32'(m_ready), 1);
        chk("edge_rdata", m_rdata, 32'hA5A5_A5A5);
        step(); s_ready_man = 1'b0; m_valid = '0; #1;
        chk("edge_tp", 32'(timeout_pulse), 0);
        step();

        // master 1 write; bus outputs idle at zero outside GRANT
        m_valid = 2'b10; m_wdata[63:32] = 32'hCAFE_BABE; m_wstrb[7:4] = 4'b0011; #1;
        chk("wr_idle_saddr", s_addr, 0);
        chk("wr_idle_swdata", s_wdata, 0);
        chk("wr_idle_swstrb", 32'(s_wstrb), 0);
        step(); #1;
        chk("wr_grant", 32'(grant), 2);
        chk("wr_swstrb", 32'(s_wstrb), 32'h3);
        chk("wr_swdata", s_wdata, 32'hCAFE_BABE);
        chk("wr_saddr", s_addr, 32'h2000_0004);
        s_ready_man = 1'b1;
        step(); s_ready_man = 1'b0; m_valid = '0; #1;
        chk("wr_rel_swdata", s_wdata, 0);
        step();

        // async reset mid-GRANT, then master 1 alone is served first
        m_valid = 2'b01;
        step(); #1;
        chk("rs_grant_pre", 32'(grant), 1);
        s_ready_man = 1'b1; resetn = 1'b0; m_valid = 2'b10; #1;
        chk("rs_svalid", 32'(s_valid), 0);
        chk("rs_grant", 32'(grant), 0);
        chk("rs_mready", 32'(m_ready), 0);
        step(); resetn = 1'b1; s_ready_man = 1'b0;
        step(); #1;
        chk("rs_regrant", 32'(grant), 2);
        chk("rs_svalid2", 32'(s_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
